// File: rtl/history_mem_arbiter_if.sv
// Single-port history memory bus with one-cycle read latency.
// The arbiter drives the master side; the memory drives mem_rdata.
interface history_mem_arbiter_if;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/history_mem_arbiter.sv
// History memory arbiter: clear sweep, pixel reads, detector write-back, CPU reads.
// Optional CPU read port is compiled in when HIST_CPU_PORT_EN is defined.
module history_mem_arbiter #(
    parameter int unsigned CLEAR_WORDS = 307200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        VGA_VS,
    input  logic        pixel_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        median_color,
    input  logic        clear_req,
    output logic        hist_valid,
    output logic [18:0] read_addr,
    output logic [9:0]  read_x,
    output logic [9:0]  read_y,
    output logic [3:0]  color_history,
    output logic        median_color_out,
    input  logic        det_we,
    input  logic [18:0] det_addr,
    input  logic [3:0]  det_history,
    input  logic        cpu_req,
    input  logic [18:0] cpu_addr,
    output logic        cpu_ack,
    output logic [3:0]  cpu_rdata,
    history_mem_arbiter_if.master mbus,
    output logic        clear_busy,
    output logic        wb_overflow
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] WAIT_VS = 2'd1;
    localparam logic [1:0] CLEAR   = 2'd2;
    localparam logic [18:0] SWEEP_LAST = 19'(CLEAR_WORDS - 1);

    logic [1:0]  state_q, state_d;
    logic [18:0] sweep_q, sweep_d;
    logic        vs_q, win_q, ovf_q, ovf_d;
    logic        wb_full_q, wb_full_d;
    logic [18:0] wb_addr_q, wb_addr_d;
    logic [3:0]  wb_data_q, wb_data_d;
    logic        tag_pix_q;
    logic [18:0] meta_addr_q;
    logic [9:0]  meta_x_q, meta_y_q;
    logic        meta_med_q;
    logic        hv_q, med_q;
    logic [18:0] raddr_q;
    logic [9:0]  rx_q, ry_q;
    logic [3:0]  color_q;

    logic [18:0] pix_addr, cpu_addr_s;
    logic        pix_ok, pix_go, wb_go, cpu_go, wb_acc, vs_fall;

    assign pix_addr = ({9'd0, pix_y} << 9) + ({9'd0, pix_y} << 7)
                    + {9'd0, pix_x};
    assign pix_ok  = pixel_valid && (pix_x < 10'd640) && (pix_y < 10'd480);
    assign pix_go  = (state_q == RUN) && pix_ok;
    assign wb_go   = (state_q == RUN) && !pix_ok && wb_full_q;
    assign wb_acc  = win_q && det_we && (state_q != CLEAR);
    assign vs_fall = vs_q && !VGA_VS;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (1'b1)
            (state_q == RUN): begin
                if (clear_req) state_d = WAIT_VS;
            end
            (state_q == WAIT_VS): begin
                if (vs_fall) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            (state_q == CLEAR): begin
                if (sweep_q == SWEEP_LAST) state_d = RUN;
                else sweep_d = sweep_q + 19'd1;
            end
            default: begin
                state_d = CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    // Overwriting a still-full buffer loses a write; a same-cycle drain does not.
    always_comb begin
        wb_full_d = wb_full_q && !wb_go;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        ovf_d     = ovf_q || (wb_acc && wb_full_q && !wb_go);
        if (wb_acc) begin
            wb_full_d = 1'b1;
            wb_addr_d = det_addr;
            wb_data_d = det_history;
        end
        if (state_d == CLEAR && state_q != CLEAR) wb_full_d = 1'b0;
    end

    always_comb begin
        mbus.mem_addr  = '0;
        mbus.mem_we    = 1'b0;
        mbus.mem_wdata = '0;
        if (state_q == CLEAR) begin
            mbus.mem_addr = sweep_q;
            mbus.mem_we   = reset;
        end else if (pix_go) begin
            mbus.mem_addr = pix_addr;
        end else if (wb_go) begin
            mbus.mem_addr  = wb_addr_q;
            mbus.mem_we    = 1'b1;
            mbus.mem_wdata = wb_data_q;
        end else if (cpu_go) begin
            mbus.mem_addr = cpu_addr_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            sweep_q     <= '0;
            vs_q        <= 1'b0;
            win_q       <= 1'b0;
            ovf_q       <= 1'b0;
            wb_full_q   <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            tag_pix_q   <= 1'b0;
            meta_addr_q <= '0;
            meta_x_q    <= '0;
            meta_y_q    <= '0;
            meta_med_q  <= 1'b0;
            hv_q        <= 1'b0;
            raddr_q     <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            color_q     <= '0;
            med_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            vs_q      <= VGA_VS;
            win_q     <= hv_q;
            ovf_q     <= ovf_d;
            wb_full_q <= wb_full_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            tag_pix_q <= pix_go;
            hv_q      <= tag_pix_q;
            if (pix_go) begin
                meta_addr_q <= pix_addr;
                meta_x_q    <= pix_x;
                meta_y_q    <= pix_y;
                meta_med_q  <= median_color;
            end
            if (tag_pix_q) begin
                color_q <= mbus.mem_rdata;
                raddr_q <= meta_addr_q;
                rx_q    <= meta_x_q;
                ry_q    <= meta_y_q;
                med_q   <= meta_med_q;
            end
        end
    end

`ifdef HIST_CPU_PORT_EN
    logic       tag_cpu_q, cpu_busy_q, cpu_ack_q;
    logic [3:0] cpu_rdata_q;

    assign cpu_addr_s = cpu_addr;
    assign cpu_go = (state_q == RUN) && !pix_ok && !wb_full_q
                 && cpu_req && !cpu_busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_cpu_q   <= 1'b0;
            cpu_busy_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            tag_cpu_q <= cpu_go;
            cpu_ack_q <= tag_cpu_q;
            if (cpu_go) cpu_busy_q <= 1'b1;
            else if (cpu_ack_q) cpu_busy_q <= 1'b0;
            if (tag_cpu_q) cpu_rdata_q <= mbus.mem_rdata;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
`else
    logic unused_cpu;
    assign unused_cpu = ^{cpu_req, cpu_addr};
    assign cpu_addr_s = '0;
    assign cpu_go     = 1'b0;
    assign cpu_ack    = 1'b0;
    assign cpu_rdata  = '0;
`endif

    assign hist_valid       = hv_q;
    assign read_addr        = raddr_q;
    assign read_x           = rx_q;
    assign read_y           = ry_q;
    assign color_history    = color_q;
    assign median_color_out = med_q;
    assign clear_busy       = (state_q != RUN);
    assign wb_overflow      = ovf_q;
endmodule
